// File: rtl/scan_controller.sv
// Digit-scan sequencer for a 4-digit 7-segment display: slot timing, anti-ghost blanking,
// frame-coherent display latching and optional leading-zero suppression.
module scan_controller #(
   parameter int DIV_WIDTH = 16,
   parameter int DIV       = 50000,
   parameter int BLANK     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        lzs,
   output logic [1:0]  sel,
   output logic [3:0]  nibble,
   output logic        blank,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(DIV - 1);
   localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'((BLANK > 0) ? BLANK - 1 : 0);
   localparam state_t               SLOT_START = (BLANK > 0) ? ST_BLANK : ST_SHOW;

   state_t                r_state;
   logic [DIV_WIDTH-1:0]  r_cnt;
   logic [1:0]            r_sel;
   logic [15:0]           r_pending;
   logic [15:0]           r_display;
   logic                  r_frame_done;

   state_t                w_state_next;
   logic [DIV_WIDTH-1:0]  w_cnt_next;
   logic [1:0]            w_sel_next;
   logic [15:0]           w_pending_next;
   logic [15:0]           w_display_next;
   logic                  w_frame_done_next;
   logic                  w_suppress;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_sel        <= '0;
         r_pending    <= '0;
         r_display    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_sel        <= w_sel_next;
         r_pending    <= w_pending_next;
         r_display    <= w_display_next;
         r_frame_done <= w_frame_done_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_sel_next        = r_sel;
      w_pending_next    = r_pending;
      w_display_next    = r_display;
      w_frame_done_next = 1'b0;

      if (load) begin
         w_pending_next = value;
      end
      // While idle nothing is being scanned, so a load can go straight to the display.
      if (load && (r_state == ST_IDLE)) begin
         w_display_next = value;
      end

      if (!en) begin
         w_state_next = ST_IDLE;
         w_cnt_next   = '0;
         w_sel_next   = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_state_next = SLOT_START;
               w_cnt_next   = '0;
               w_sel_next   = '0;
            end
            ST_BLANK: begin
               w_cnt_next = r_cnt + 1'b1;
               if (r_cnt == BLANK_LAST) begin
                  w_state_next = ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (r_cnt == DIV_LAST) begin
                  w_cnt_next   = '0;
                  w_sel_next   = r_sel + 2'd1;
                  w_state_next = SLOT_START;
                  // Frame boundary: a coincident load beats the older pending value.
                  if (r_sel == 2'd3) begin
                     w_frame_done_next = 1'b1;
                     w_display_next    = load ? value : r_pending;
                  end
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
               w_sel_next   = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_suppress = 1'b0;
      if (lzs) begin
         unique case (r_sel)
            2'd3:    w_suppress = (r_display[15:12] == 4'h0);
            2'd2:    w_suppress = (r_display[15:8]  == 8'h00);
            2'd1:    w_suppress = (r_display[15:4]  == 12'h000);
            default: w_suppress = 1'b0;
         endcase
      end
   end

   assign sel        = r_sel;
   assign nibble     = r_display[{r_sel, 2'b00} +: 4];
   assign blank      = (r_state != ST_SHOW) | w_suppress;
   assign frame_done = r_frame_done;

endmodule
